// File: rtl/image_pipe_proc.sv
// image_pipe_proc: per-lane saturating brightness offset on a valid/busy
// pixel stream. The offset is latched on the first beat of each frame.
// Results are buffered in a small FIFO whose head drives the output port.
// Completed output frames are counted.
module image_pipe_proc #(
    parameter int DW_IN      = 32,
    parameter int DW_OUT     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW_IN-1:0]  is_data_in,
    input  logic              is_valid_in,
    input  logic              is_end_in,
    output logic              is_busy_out,
    output logic [DW_OUT-1:0] im_data_out,
    output logic              im_valid_out,
    output logic              im_end_out,
    input  logic              im_busy_in,
    input  logic [7:0]        cfg_offset,
    output logic [15:0]       frame_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int LANES = DW_IN / 8;
    localparam int EW    = DW_IN + 1;   // {end, data}
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Add the offset to each 8-bit lane in 9 bits and clamp at 255.
    function automatic logic [DW_IN-1:0] sat_add(input logic [DW_IN-1:0] d,
                                                 input logic [7:0]       off);
        logic [DW_IN-1:0] r;
        logic [8:0]       sum;
        r = {DW_IN{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            sum = {1'b0, d[8*i +: 8]} + {1'b0, off};
            r[8*i +: 8] = sum[8] ? 8'hFF : sum[7:0];
        end
        return r;
    endfunction

    logic [EW-1:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              busy_r;
    logic              valid_r;
    logic              end_r;
    logic [DW_OUT-1:0] data_r;
    logic [15:0]       frame_cnt_r;
    logic              in_frame_r;
    logic [7:0]        offset_r;

    logic              push_s;
    logic              pop_s;
    logic [7:0]        off_s;
    logic [EW-1:0]     entry_s;
    logic [CW-1:0]     count_after_pop_s;
    logic [CW-1:0]     count_next_s;
    logic [AW-1:0]     wr_ptr_next_s;
    logic [AW-1:0]     rd_ptr_next_s;
    logic [EW-1:0]     head_next_s;

    assign is_busy_out  = busy_r;
    assign im_valid_out = valid_r;
    assign im_data_out  = data_r;
    assign im_end_out   = end_r;
    assign frame_cnt    = frame_cnt_r;

    // Transfer decode, pixel processing and next FIFO bookkeeping / head word.
    always_comb begin
        push_s  = is_valid_in & ~busy_r;
        pop_s   = valid_r & ~im_busy_in;
        // First beat of a frame uses the live offset; later beats the latched one.
        if (in_frame_r) begin
            off_s = offset_r;
        end else begin
            off_s = cfg_offset;
        end
        entry_s = {is_end_in, sat_add(is_data_in, off_s)};

        if (pop_s) begin
            count_after_pop_s = count_r - CW'(1'b1);
            rd_ptr_next_s     = rd_ptr_r + AW'(1'b1);
        end else begin
            count_after_pop_s = count_r;
            rd_ptr_next_s     = rd_ptr_r;
        end

        if (push_s) begin
            count_next_s  = count_after_pop_s + CW'(1'b1);
            wr_ptr_next_s = wr_ptr_r + AW'(1'b1);
        end else begin
            count_next_s  = count_after_pop_s;
            wr_ptr_next_s = wr_ptr_r;
        end

        // Head register: bypass the beat being written when it lands in an
        // otherwise empty FIFO; zero when nothing is buffered.
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = {EW{1'b0}};
        end else if (push_s && (count_after_pop_s == {CW{1'b0}})) begin
            head_next_s = entry_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage write on every accepted input beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Registered port state: busy, valid and head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= {DW_OUT{1'b0}};
            end_r   <= 1'b0;
        end else begin
            busy_r  <= (count_next_s == DEPTH_C);
            valid_r <= (count_next_s != {CW{1'b0}});
            data_r  <= head_next_s[DW_IN-1:0];
            end_r   <= head_next_s[DW_IN];
        end
    end

    // Frame tracking: latch the offset on a frame's first beat, leave the
    // frame on an end beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame_r <= 1'b0;
            offset_r   <= 8'h00;
        end else if (push_s) begin
            if (!in_frame_r) begin
                offset_r <= cfg_offset;
            end else begin
                offset_r <= offset_r;
            end
            in_frame_r <= ~is_end_in;
        end else begin
            in_frame_r <= in_frame_r;
            offset_r   <= offset_r;
        end
    end

    // Count frames whose end beat leaves the block; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'h0000;
        end else if (pop_s && end_r) begin
            frame_cnt_r <= frame_cnt_r + 16'h0001;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

endmodule

// File: tb/tb_image_pipe_proc.sv
// tb_image_pipe_proc: directed stimulus with a queue-based reference model
// and a per-cycle compare process, plus hand-computed literal checks.
module tb_image_pipe_proc;

    logic        clk;
    logic        rst_n;
    logic [31:0] is_data_in;
    logic        is_valid_in;
    logic        is_end_in;
    logic        is_busy_out;
    logic [31:0] im_data_out;
    logic        im_valid_out;
    logic        im_end_out;
    logic        im_busy_in;
    logic [7:0]  cfg_offset;
    logic [15:0] frame_cnt;

    image_pipe_proc #(.DW_IN(32), .DW_OUT(32), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .is_data_in   (is_data_in),
        .is_valid_in  (is_valid_in),
        .is_end_in    (is_end_in),
        .is_busy_out  (is_busy_out),
        .im_data_out  (im_data_out),
        .im_valid_out (im_valid_out),
        .im_end_out   (im_end_out),
        .im_busy_in   (im_busy_in),
        .cfg_offset   (cfg_offset),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } beat_t;

    beat_t       q[$];
    logic        m_busy     = 1'b0;
    logic        m_in_frame = 1'b0;
    logic [7:0]  m_off      = 8'h00;
    logic [15:0] m_fc       = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bright(input logic [31:0] w, input logic [7:0] o);
        logic [31:0] r;
        int s;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            s = int'(w[8*i +: 8]) + int'(o);
            r[8*i +: 8] = (s > 255) ? 8'hFF : 8'(s);
        end
        return r;
    endfunction

    // Reference model: a FIFO of expected output beats.
    initial begin
        beat_t b;
        logic acc;
        logic pop;
        logic [7:0] off;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_busy = 1'b0; m_in_frame = 1'b0; m_off = 8'h00; m_fc = 16'h0000;
            end else begin
                acc = is_valid_in && !m_busy;
                pop = (q.size() != 0) && !im_busy_in;
                off = m_in_frame ? m_off : cfg_offset;
                if (pop) begin
                    if (q[0].e) m_fc = m_fc + 16'h0001;
                    void'(q.pop_front());
                end
                if (acc) begin
                    if (!m_in_frame) m_off = cfg_offset;
                    if (is_end_in) m_in_frame = 1'b0;
                    else m_in_frame = 1'b1;
                    b.d = bright(is_data_in, off);
                    b.e = is_end_in;
                    q.push_back(b);
                end
                m_busy = (q.size() == 4);
            end
        end
    end

    // Compare DUT against model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("valid", 32'(im_valid_out), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("data", im_data_out, q[0].d);
                chk("end", 32'(im_end_out), 32'(q[0].e));
            end
            chk("busy", 32'(is_busy_out), 32'(m_busy));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until taken (bounded).
    task automatic send(input logic [31:0] d, input logic e);
        int guard;
        logic b;
        is_data_in = d; is_end_in = e; is_valid_in = 1'b1;
        guard = 0;
        do begin
            b = is_busy_out;
            tick();
            guard++;
        end while (b && guard < 50);
        if (b) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: beat %h not accepted within 50 cycles", d);
        end
        is_valid_in = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 64) begin
            tick();
            guard++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; is_data_in = 32'h0; is_valid_in = 1'b0; is_end_in = 1'b0;
        im_busy_in = 1'b0; cfg_offset = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(im_valid_out), 32'd0);
        chk("rst_data", im_data_out, 32'h0);
        chk("rst_busy", 32'(is_busy_out), 32'd0);
        chk("rst_fc", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;

        // Single beat frame
        cfg_offset = 8'h10;
        send(32'h007FF001, 1'b1);
        chk("single_data", im_data_out, 32'h108FFF11);
        chk("single_end", 32'(im_end_out), 32'd1);
        tick();
        chk("single_fc", 32'(frame_cnt), 32'd1);

        // Offset latched per frame
        cfg_offset = 8'h02;
        send(32'h01010101, 1'b0);
        chk("latch_b1", im_data_out, 32'h03030303);
        cfg_offset = 8'h40;
        send(32'h01010101, 1'b0);
        chk("latch_b2", im_data_out, 32'h03030303);
        send(32'h01010101, 1'b1);
        chk("latch_b3", im_data_out, 32'h03030303);
        tick();
        send(32'h01010101, 1'b1);
        chk("latch_next", im_data_out, 32'h41414141);
        tick();

        // Backpressure: fill, hold a fifth beat, release
        im_busy_in = 1'b1;
        cfg_offset = 8'hC0;
        for (int i = 0; i < 4; i++) begin
            send(32'h10203040 + 32'(i), (i == 3) ? 1'b1 : 1'b0);
            if (i == 2) chk("bp_not_full", 32'(is_busy_out), 32'd0);
        end
        chk("bp_full", 32'(is_busy_out), 32'd1);
        chk("bp_head", im_data_out, 32'hD0E0F0FF);
        is_data_in = 32'h55AA55AA; is_end_in = 1'b1; is_valid_in = 1'b1;
        tick(); tick();
        chk("bp_held", 32'(is_busy_out), 32'd1);
        im_busy_in = 1'b0;
        tick();
        chk("bp_release", 32'(is_busy_out), 32'd0);
        tick();
        is_valid_in = 1'b0;
        drain();
        chk("bp_fc", 32'(frame_cnt), 32'd5);

        // Streaming, no backpressure
        cfg_offset = 8'hF0;
        is_valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            is_data_in = 32'h01010101 * 32'(i);
            is_end_in = (i == 15) ? 1'b1 : 1'b0;
            tick();
            chk("stream_busy", 32'(is_busy_out), 32'd0);
        end
        is_valid_in = 1'b0;
        drain();

        // Reset in the middle of a frame
        im_busy_in = 1'b1;
        cfg_offset = 8'h05;
        for (int i = 0; i < 3; i++) send(32'h11111111, 1'b0);
        chk("mid_count", 32'(im_valid_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(im_valid_out), 32'd0);
        chk("mr_data", im_data_out, 32'h0);
        chk("mr_end", 32'(im_end_out), 32'd0);
        chk("mr_fc", 32'(frame_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cfg_offset = 8'h20;
        send(32'h01010101, 1'b1);
        chk("mr_new_off", im_data_out, 32'h21212121);
        im_busy_in = 1'b0;
        tick();
        chk("mr_fc1", 32'(frame_cnt), 32'd1);

        // Frame counter wrap: reset, then 65536 single-beat frames
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        is_valid_in = 1'b1; is_end_in = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            is_data_in = 32'(i);
            tick();
        end
        is_valid_in = 1'b0;
        drain();
        chk("wrap_ffff", 32'(frame_cnt), 32'h0000FFFF);
        send(32'h0, 1'b1);
        tick();
        chk("wrap_zero", 32'(frame_cnt), 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
